// File: rtl/ppfifo_to_axis_video_pkg.sv
// Shared definitions for the ppfifo_to_axis_video read-side controller:
// FSM state encoding, pixel-word bit positions and RGB332 -> RGB888 expansion.
package ppfifo_to_axis_video_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        LOAD     = 3'd2,
        HOLD     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam int SIZE_W  = 24;
    localparam int WORD_W  = 25;
    localparam int PIX_W   = 24;

    // Pixel word layout: [8] start of frame, [7:5] red, [4:2] green, [1:0] blue.
    localparam int SOF_BIT = 8;
    localparam int RED_MSB = 7;
    localparam int GRN_MSB = 4;
    localparam int BLU_MSB = 1;

    // Bit replication keeps full-scale codes at full scale (7 -> 0xFF, 3 -> 0xFF).
    function automatic logic [PIX_W-1:0] rgb332_to_rgb888(input logic [7:0] pix);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = pix[RED_MSB -: 3];
        g = pix[GRN_MSB -: 3];
        b = pix[BLU_MSB -: 2];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

endpackage

// File: rtl/ppfifo_to_axis_video_if.sv
// AXI4-Stream video bus between ppfifo_to_axis_video and its consumer.
interface ppfifo_to_axis_video_if;
    import ppfifo_to_axis_video_pkg::*;

    // Handshake: a beat transfers on a rising clk edge where tvalid && tready.
    // Once tvalid is high, tvalid/tdata/tuser/tlast hold until that transfer;
    // tvalid never depends combinationally on tready.
    logic             tvalid;
    logic             tready;
    logic [PIX_W-1:0] tdata;   // {R8, G8, B8}
    logic             tuser;   // start of frame
    logic             tlast;   // end of line

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);

endinterface

// File: rtl/ppfifo_to_axis_video_line_tracker.sv
// axis_video_line_tracker: pixel-in-line counter, tlast generation and sof
// resync detection. Optional stats counters under PPFIFO_TO_AXIS_VIDEO_STATS_EN.
module axis_video_line_tracker
    import ppfifo_to_axis_video_pkg::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int PCNT_WIDTH = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,      // a new word is captured into the output register
    input  logic        sof,       // sof bit of that word, meaningful with load
    input  logic        accept,    // the held beat is transferred
    output logic        tlast
`ifdef PPFIFO_TO_AXIS_VIDEO_STATS_EN
    ,
    input  logic        beat_sof,  // tuser of the beat being accepted
    output logic [31:0] frame_count,
    output logic [15:0] resync_count
`endif
);

    localparam logic [PCNT_WIDTH-1:0] LAST_PIX = PCNT_WIDTH'(LINE_WIDTH - 1);

    logic [PCNT_WIDTH-1:0] pcnt;
    logic [PCNT_WIDTH-1:0] eff_pcnt;

    // A start-of-frame word always begins a new line at pixel 0.
    assign eff_pcnt = sof ? '0 : pcnt;

    // Pixel counter: resync on load, advance (with wrap) on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt  <= '0;
            tlast <= 1'b0;
        end else if (load) begin
            pcnt  <= eff_pcnt;
            tlast <= (eff_pcnt == LAST_PIX);
        end else if (accept) begin
            pcnt  <= (pcnt == LAST_PIX) ? '0 : pcnt + PCNT_WIDTH'(1);
            tlast <= 1'b0;
        end
    end

`ifdef PPFIFO_TO_AXIS_VIDEO_STATS_EN
    // Frame and resync counters; resync saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count  <= '0;
            resync_count <= '0;
        end else begin
            if (accept && beat_sof)
                frame_count <= frame_count + 32'd1;
            if (load && sof && (pcnt != '0) && (resync_count != 16'hFFFF))
                resync_count <= resync_count + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/ppfifo_to_axis_video.sv
// ppfifo_to_axis_video: ping-pong FIFO read controller that turns RGB332 pixel
// words into an AXI4-Stream video stream (tuser = sof, tlast = end of line).
// One beat per two clocks: a word is loaded, then held until accepted.
// Optional stats outputs enabled by PPFIFO_TO_AXIS_VIDEO_STATS_EN.
module ppfifo_to_axis_video
    import ppfifo_to_axis_video_pkg::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int PCNT_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic                   i_fifo_ready,
    output logic                   o_fifo_activate,
    input  logic [SIZE_W-1:0]      i_fifo_size,
    output logic                   o_fifo_stb,
    input  logic [WORD_W-1:0]      i_fifo_data,
    ppfifo_to_axis_video_if.master axis,
    output logic                   o_busy,
    output state_t                 dbg_state
`ifdef PPFIFO_TO_AXIS_VIDEO_STATS_EN
    ,
    output logic [31:0]            o_frame_count,
    output logic [15:0]            o_resync_count
`endif
);

    state_t              state;
    state_t              next_state;
    logic                load;
    logic                accept;
    logic [SIZE_W-1:0]   size_q;
    logic [SIZE_W-1:0]   count;
    logic                tlast_w;
    logic                unused_bits;

    assign unused_bits = ^i_fifo_data[WORD_W-1:SOF_BIT+1];

    assign o_fifo_stb = load;
    assign o_busy     = (state != IDLE);
    assign dbg_state  = state;
    assign axis.tlast = tlast_w;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode plus the load/accept strobes.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE:     if (i_enable && i_fifo_ready) next_state = PREFETCH;
            PREFETCH: next_state = (i_fifo_size == '0) ? RELEASE : LOAD;
            LOAD: begin
                load       = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                if (axis.tvalid && axis.tready) begin
                    accept     = 1'b1;
                    next_state = (count < size_q) ? LOAD : RELEASE;
                end
            end
            RELEASE:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Block ownership, word counting and the output beat register.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_fifo_activate <= 1'b0;
            size_q          <= '0;
            count           <= '0;
            axis.tvalid     <= 1'b0;
            axis.tdata      <= '0;
            axis.tuser      <= 1'b0;
        end else begin
            if (state == IDLE && next_state == PREFETCH) begin
                o_fifo_activate <= 1'b1;
                count           <= '0;
            end
            if (state == PREFETCH)
                size_q <= i_fifo_size;
            // Activate stays high through RELEASE so it drops for at least one IDLE cycle.
            if (state == RELEASE)
                o_fifo_activate <= 1'b0;
            if (load) begin
                axis.tvalid <= 1'b1;
                axis.tdata  <= rgb332_to_rgb888(i_fifo_data[7:0]);
                axis.tuser  <= i_fifo_data[SOF_BIT];
                count       <= count + SIZE_W'(1);
            end
            if (accept) begin
                axis.tvalid <= 1'b0;
                axis.tuser  <= 1'b0;
            end
        end
    end

    axis_video_line_tracker #(
        .LINE_WIDTH (LINE_WIDTH),
        .PCNT_WIDTH (PCNT_WIDTH)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .sof          (i_fifo_data[SOF_BIT]),
        .accept       (accept),
        .tlast        (tlast_w)
`ifdef PPFIFO_TO_AXIS_VIDEO_STATS_EN
        ,
        .beat_sof     (axis.tuser),
        .frame_count  (o_frame_count),
        .resync_count (o_resync_count)
`endif
    );

endmodule

// File: doc/ppfifo_to_axis_video.md
Name: ppfifo_to_axis_video

Overview:
- Read-side controller for the NES pixel block FIFO.
- Sequences the ping-pong read handshake: ready, activate, strobe, release.
- Unpacks each 25-bit pixel word and expands RGB332 to RGB888.
- Emits an AXI4-Stream video stream: tuser marks start of frame, tlast marks end of line.
- Runs entirely in the FIFO read clock domain.

Parameters:
- LINE_WIDTH, 256, active pixels per line; tlast asserted on pixel LINE_WIDTH-1.
- PCNT_WIDTH, 9, width of the pixel-in-line counter; must satisfy 2^PCNT_WIDTH >= LINE_WIDTH.

Ports:
- clk  in  1  clock; FIFO read clock.
- rst  in  1  reset, synchronous, active-high.
- i_enable  in  1  allow new block activations.
- i_fifo_ready  in  1  a filled block is available.
- o_fifo_activate  out  1  read block owned.
- i_fifo_size  in  24  word count of the activated block; sampled the cycle after activation.
- o_fifo_stb  out  1  advance FIFO read pointer.
- i_fifo_data  in  25  pixel word; bit8 sof, [7:5] red, [4:2] green, [1:0] blue, [24:9] ignored.
- o_axis_tvalid  out  1  stream valid.
- i_axis_tready  in  1  stream ready.
- o_axis_tdata  out  24  {R8,G8,B8}.
- o_axis_tuser  out  1  start of frame.
- o_axis_tlast  out  1  end of line.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-block drops activate immediately and discards any held beat.
- FIFO data timing: i_fifo_data is valid 1 cycle after activate rises and 1 cycle after each o_fifo_stb.
- States:
  - IDLE: if i_enable && i_fifo_ready, set o_fifo_activate=1, clear word count, go to PREFETCH.
  - PREFETCH: wait 1 cycle. Latch size = i_fifo_size. If size==0, go to RELEASE; else go to LOAD.
  - LOAD: output register is empty. Capture i_fifo_data, set tvalid=1, pulse o_fifo_stb for 1 cycle, increment count, go to HOLD.
  - HOLD: on tvalid && tready, go to LOAD if count<size, otherwise go to RELEASE with tvalid=0. While tready=0, tdata/tuser/tlast/tvalid stay stable.
  - RELEASE: o_fifo_activate=0 for 1 cycle, then IDLE. No same-cycle re-activation.
- Throughput: at most 1 beat per 2 clocks. Accepting a beat and loading the next word take separate cycles.
- Colour expansion (bit replication): R8={r,r,r[2:1]}, G8={g,g,g[2:1]}, B8={b,b,b,b}.
- Pixel counter pcnt:
  - tuser = word bit8.
  - A word with sof=1 forces that pixel's pcnt to 0 (resync).
  - tlast = (effective pcnt == LINE_WIDTH-1).
  - On accepted beat: pcnt wraps to 0 after LINE_WIDTH-1, otherwise increments.
- Lines may span block boundaries; pcnt persists across blocks.
- i_enable deasserted mid-block: the current block drains completely; no new activation.
- o_fifo_stb is never asserted outside LOAD and never more than size times per block.

Optional Feature:
- Macro: PPFIFO_TO_AXIS_VIDEO_STATS_EN.
- With the macro:
  - Adds outputs o_frame_count[31:0] (increments on each accepted beat with tuser=1).
  - Adds o_resync_count[15:0] (increments when sof=1 arrives with pcnt!=0; saturates at 0xFFFF).
  - Both counters reset to 0.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - State enum (IDLE, PREFETCH, LOAD, HOLD, RELEASE).
  - Bit-position constants: SOF_BIT=8, RED_MSB=7, GRN_MSB=4, BLU_MSB=1.
  - Function rgb332_to_rgb888.
- Natural sub-module: axis_video_line_tracker. Owns pcnt, tlast, resync detection and the optional stats counters. Driven by beat-accept and sof inputs.

Test Plan:
- Reset, then i_fifo_ready=1, size=4, words 0x1FF,0x0E0,0x01C,0x003, tready=1 -> 4 beats:
  - tdata 0xFFFFFF with tuser=1,
  - then 0xFF0000,
  - then 0x00FF00,
  - then 0x0000FF;
  - 4 strobes total, then activate falls.
- LINE_WIDTH=256; 2 blocks of 200 words, first word sof=1, tready=1 -> tlast only on beat 256 (second block, word 56); pcnt continues across the block gap.
- tready held 0 for 5 cycles during beat 3 -> tdata/tuser/tlast stable, o_fifo_stb stays 0 until accept.
- size=0 block -> activate high 2 cycles, no strobe, no tvalid, back to IDLE.
- sof=1 on pixel 100 -> that beat has tuser=1, pcnt restarts; tlast arrives 255 beats later. With STATS_EN: resync_count=1, frame_count increments.
- rst asserted during HOLD -> next cycle tvalid=0, o_fifo_activate=0, o_busy=0; no further strobes.
